// File: rtl/dm_responder_if.sv
// Data-memory port between the core and dm_responder: one access per cycle, qualified
// by the i_ren/i_wen strobes. There is no valid/ready pair and no back-pressure.
interface dm_responder_if;
  logic [31:0] i_addr;
  logic [31:0] i_wd;
  logic [3:0]  i_wen;
  logic        i_ren;
  logic [31:0] o_rd;
  logic        o_err;

  // Strobe protocol: a load is accepted whenever i_ren=1 (o_rd is valid in the same
  // cycle), and a store whenever any i_wen bit is set (it commits on the next rising
  // edge). Neither side may stall the other.
  modport master (output i_addr, i_wd, i_wen, i_ren, input o_rd, o_err);
  modport slave  (input i_addr, i_wd, i_wen, i_ren, output o_rd, o_err);
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word loads, byte-lane stores, and a
// memory-mapped 64-bit timer with a compare interrupt plus a GPIO output register.
module dm_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  dm_responder_if.slave  bus,
  output logic           o_irq,
  output logic [31:0]    o_gpio
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_cnt_lo, r_cnt_hi, r_cmp_lo, r_cmp_hi, r_gpio;
  logic [1:0]  r_ctrl;
  logic        r_pend;

  logic          w_ram, w_mmio, w_reg_wr, w_clr, w_hit;
  logic [AW-1:0] w_word;
  logic [3:0]    w_sel;
  logic [63:0]   w_cnt_nxt;
  logic [31:0]   w_reg_rd;
  logic [1:0]    w_unused_addr;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++)
      if (lanes[k]) res[8*k +: 8] = new_v[8*k +: 8];
    return res;
  endfunction

  assign w_ram         = (bus.i_addr[31:AW+2] == '0);
  assign w_mmio        = (bus.i_addr[31:6] == MMIO_BASE[31:6]);
  assign w_word        = bus.i_addr[AW+1:2];
  assign w_sel         = bus.i_addr[5:2];
  assign w_unused_addr = bus.i_addr[1:0];
  assign w_reg_wr      = w_mmio & (|bus.i_wen);
  assign w_clr         = w_reg_wr & (w_sel == 4'h5) & bus.i_wen[0] & bus.i_wd[0];
  assign w_hit         = ({r_cnt_hi, r_cnt_lo} >= {r_cmp_hi, r_cmp_lo});

  // A software write to either counter half replaces the increment for the whole 64 bits.
  always_comb begin
    w_cnt_nxt = {r_cnt_hi, r_cnt_lo};
    if (w_reg_wr && (w_sel == 4'h0))
      w_cnt_nxt[31:0] = f_merge(r_cnt_lo, bus.i_wd, bus.i_wen);
    else if (w_reg_wr && (w_sel == 4'h1))
      w_cnt_nxt[63:32] = f_merge(r_cnt_hi, bus.i_wd, bus.i_wen);
    else if (r_ctrl[0])
      w_cnt_nxt = {r_cnt_hi, r_cnt_lo} + 64'd1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt_lo <= '0;
      r_cnt_hi <= '0;
      r_cmp_lo <= '1;
      r_cmp_hi <= '1;
      r_ctrl   <= '0;
      r_pend   <= 1'b0;
      r_gpio   <= '0;
    end else begin
      {r_cnt_hi, r_cnt_lo} <= w_cnt_nxt;
      if (w_reg_wr && (w_sel == 4'h2)) r_cmp_lo <= f_merge(r_cmp_lo, bus.i_wd, bus.i_wen);
      if (w_reg_wr && (w_sel == 4'h3)) r_cmp_hi <= f_merge(r_cmp_hi, bus.i_wd, bus.i_wen);
      if (w_reg_wr && (w_sel == 4'h4) && bus.i_wen[0]) r_ctrl <= bus.i_wd[1:0];
      if (w_reg_wr && (w_sel == 4'h6)) r_gpio <= f_merge(r_gpio, bus.i_wd, bus.i_wen);
      // Set has priority over the W1C clear.
      r_pend <= w_hit | (r_pend & ~w_clr);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++)
      if (w_ram && bus.i_wen[k]) r_mem[w_word][8*k +: 8] <= bus.i_wd[8*k +: 8];
  end

  always_comb begin
    w_reg_rd = '0;
    case (w_sel)
      4'h0:    w_reg_rd = r_cnt_lo;
      4'h1:    w_reg_rd = r_cnt_hi;
      4'h2:    w_reg_rd = r_cmp_lo;
      4'h3:    w_reg_rd = r_cmp_hi;
      4'h4:    w_reg_rd = {30'd0, r_ctrl};
      4'h5:    w_reg_rd = {31'd0, r_pend};
      4'h6:    w_reg_rd = r_gpio;
      default: w_reg_rd = '0;
    endcase
  end

  always_comb begin
    bus.o_rd = '0;
    if (bus.i_ren) begin
      if (w_ram)       bus.o_rd = r_mem[w_word];
      else if (w_mmio) bus.o_rd = w_reg_rd;
    end
  end

  assign bus.o_err = (bus.i_ren | (|bus.i_wen)) & ~w_ram & ~w_mmio;
  assign o_irq     = r_pend & r_ctrl[1];
  assign o_gpio    = r_gpio;
endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed bench for dm_responder. Each driven cycle pushes its expected
// outputs into a queue, and a negedge monitor pops them and compares.
module tb_dm_responder;
  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] B         = 32'h8000_0000;
  localparam int          W         = 67;

  logic i_clk = 1'b0;
  logic i_rstn;
  logic o_irq;
  logic [31:0] o_gpio;

  dm_responder_if bus ();

  dm_responder #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(B)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .bus(bus), .o_irq(o_irq), .o_gpio(o_gpio)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic mon_chk = 1'b0;

  // Reference model state
  logic [31:0] m_mem   [int];
  logic [3:0]  m_known [int];
  logic [63:0] m_cnt, m_cmp;
  logic [1:0]  m_ctrl;
  logic        m_pend;
  logic [31:0] m_gpio;

  task automatic model_reset();
    m_cnt = 64'd0; m_cmp = '1; m_ctrl = 2'd0; m_pend = 1'b0; m_gpio = 32'd0;
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] we);
    logic [31:0] r = o;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic bit is_ram(logic [31:0] a);
    return a < MEM_WORDS * 4;
  endfunction

  function automatic bit is_mmio(logic [31:0] a);
    return (a & 32'hFFFF_FFC0) == B;
  endfunction

  // Expected {rd_known, rd, err, irq, gpio} for the current inputs and model state.
  function automatic logic [W-1:0] predict(logic [31:0] a, logic [3:0] we, logic re);
    logic [31:0] rd = 32'd0;
    logic known = 1'b1;
    int idx = int'(a >> 2);
    if (re) begin
      if (is_ram(a)) begin
        if (m_known.exists(idx) && m_known[idx] == 4'hF) rd = m_mem[idx];
        else known = 1'b0;
      end else if (is_mmio(a)) begin
        case ((a >> 2) & 32'hF)
          0: rd = m_cnt[31:0];
          1: rd = m_cnt[63:32];
          2: rd = m_cmp[31:0];
          3: rd = m_cmp[63:32];
          4: rd = {30'd0, m_ctrl};
          5: rd = {31'd0, m_pend};
          6: rd = m_gpio;
          default: rd = 32'd0;
        endcase
      end
    end
    return {known, rd, (re || we != 0) && !is_ram(a) && !is_mmio(a), m_pend && m_ctrl[1], m_gpio};
  endfunction

  task automatic model_edge(logic [31:0] a, logic [31:0] d, logic [3:0] we);
    logic [63:0] cnt_n = m_cnt;
    logic [63:0] cmp_n = m_cmp;
    logic [1:0]  ctrl_n = m_ctrl;
    logic [31:0] gpio_n = m_gpio;
    logic        clr = 1'b0;
    logic        cnt_wr = 1'b0;
    int idx = int'(a >> 2);
    if (is_ram(a)) begin
      if (!m_mem.exists(idx)) begin m_mem[idx] = 32'd0; m_known[idx] = 4'd0; end
      m_mem[idx] = merge(m_mem[idx], d, we);
      m_known[idx] = m_known[idx] | we;
    end
    if (is_mmio(a) && we != 0) begin
      case ((a >> 2) & 32'hF)
        0: begin cnt_n[31:0]  = merge(m_cnt[31:0], d, we);  cnt_wr = 1'b1; end
        1: begin cnt_n[63:32] = merge(m_cnt[63:32], d, we); cnt_wr = 1'b1; end
        2: cmp_n[31:0]  = merge(m_cmp[31:0], d, we);
        3: cmp_n[63:32] = merge(m_cmp[63:32], d, we);
        4: if (we[0]) ctrl_n = d[1:0];
        5: clr = we[0] && d[0];
        6: gpio_n = merge(m_gpio, d, we);
        default: ;
      endcase
    end
    if (!cnt_wr && m_ctrl[0]) cnt_n = m_cnt + 64'd1;
    m_pend = (m_cnt >= m_cmp) || (m_pend && !clr);
    m_cnt = cnt_n; m_cmp = cmp_n; m_ctrl = ctrl_n; m_gpio = gpio_n;
  endtask

  // Drives one cycle starting now (between edges) and ends 1 time unit after the edge.
  task automatic cycle(logic [31:0] a, logic [31:0] d, logic [3:0] we, logic re);
    bus.i_addr = a; bus.i_wd = d; bus.i_wen = we; bus.i_ren = re;
    exp_q.push_back(predict(a, we, re));
    mon_chk = 1'b1;
    @(posedge i_clk);
    model_edge(a, d, we);
    #1;
    mon_chk = 1'b0;
  endtask

  task automatic rd(logic [31:0] a);
    cycle(a, 32'd0, 4'h0, 1'b1);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] we = 4'hF);
    cycle(a, d, we, 1'b0);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_chk) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (e[66]) chk("rd", bus.o_rd, e[65:34]);
        chk("err", {31'd0, bus.o_err}, {31'd0, e[33]});
        chk("irq", {31'd0, o_irq}, {31'd0, e[32]});
        chk("gpio", o_gpio, e[31:0]);
      end
    end
  end

  initial begin
    i_rstn = 1'b0;
    bus.i_addr = 32'd0; bus.i_wd = 32'd0; bus.i_wen = 4'h0; bus.i_ren = 1'b0;
    model_reset();
    @(posedge i_clk); #1;
    i_rstn = 1'b1;

    // Reset state
    rd(B + 32'h08); rd(B + 32'h0C); rd(B + 32'h00); rd(B + 32'h10); rd(B + 32'h14); rd(B + 32'h18);

    // RAM byte lanes
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h10, 32'h0000_0055, 4'b0001);
    rd(32'h10);
    chk("ram_lane_const", bus.o_rd, 32'hDEAD_BE55);
    rd(32'h13);
    cycle(32'h10, 32'd0, 4'h0, 1'b0);

    // Counter carry across the 32-bit boundary, then a write while counting
    wr(B + 32'h00, 32'hFFFF_FFFE);
    wr(B + 32'h04, 32'h0);
    wr(B + 32'h10, 32'h1);
    rd(B + 32'h00); rd(B + 32'h04); rd(B + 32'h00); rd(B + 32'h04);
    wr(B + 32'h00, 32'h0000_1000);
    rd(B + 32'h00); rd(B + 32'h04);

    // Compare and interrupt
    wr(B + 32'h10, 32'h0);
    wr(B + 32'h00, 32'h0);
    wr(B + 32'h04, 32'h0);
    wr(B + 32'h0C, 32'h0);
    wr(B + 32'h08, 32'h5);
    wr(B + 32'h10, 32'h3);
    for (int i = 0; i < 9; i++) rd(B + 32'h00);
    rd(B + 32'h14);
    wr(B + 32'h14, 32'h1);
    rd(B + 32'h14);
    wr(B + 32'h08, 32'hFFFF_FFFF);
    wr(B + 32'h0C, 32'hFFFF_FFFF);
    wr(B + 32'h14, 32'h1);
    rd(B + 32'h14); rd(B + 32'h14);

    // GPIO byte lanes
    wr(B + 32'h18, 32'h1234_5678);
    wr(B + 32'h18, 32'hAB00_0000, 4'b1000);
    rd(B + 32'h18);
    chk("gpio_lane_const", o_gpio, 32'hAB34_5678);

    // Unmapped and reserved window
    rd(32'h4000_0000);
    wr(32'h4000_0000, 32'hFFFF_FFFF);
    rd(B + 32'h20);
    wr(B + 32'h20, 32'hFFFF_FFFF);
    rd(B + 32'h18); rd(32'h10);

    // Asynchronous reset with counter running and PEND set
    wr(B + 32'h0C, 32'h0);
    wr(B + 32'h08, 32'h0);
    rd(B + 32'h14); rd(B + 32'h14);
    bus.i_addr = B; bus.i_wd = 32'd0; bus.i_wen = 4'h0; bus.i_ren = 1'b1;
    #1 i_rstn = 1'b0;
    #1;
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    chk("rst_gpio", o_gpio, 32'd0);
    chk("rst_cnt", bus.o_rd, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    #1 i_rstn = 1'b1;
    model_reset();
    rd(B + 32'h08); rd(B + 32'h00); rd(B + 32'h14);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [3:0]  we;
      int kind = $urandom_range(0, 9);
      if (kind < 5)      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else if (kind < 9) a = B | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else               a = 32'h4000_0000 | ($urandom_range(0, 255) << 2);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle(a, $urandom, we, 1'($urandom_range(0, 1)));
    end

    @(negedge i_clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the single-cycle core's DM port: answers word-wide loads combinationally, commits byte-lane stores on the clock edge, and hosts a small memory-mapped timer/GPIO block. It sits between the core's DM outputs and the system, replacing a bare RAM model. It owns all data-side state: the RAM array, a 64-bit cycle counter, a compare/interrupt unit and a GPIO output register.

## Interface
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two)
- MMIO_BASE, 32'h8000_0000, base byte address of the register window (64-byte aligned)
- i_clk  in  1  rising-edge clock
- i_rstn  in  1  reset; asynchronous and active-low
- i_addr  in  32  byte address from the core's ALU result
- i_wd  in  32  store data (rs2, unshifted)
- i_wen  in  4  byte-lane write enables; bit k writes i_wd[8k+7:8k]
- i_ren  in  1  load strobe
- o_rd  out  32  read data, full word; the core's LSU extracts and extends
- o_irq  out  1  timer interrupt, level
- o_gpio  out  32  GPIO output register
- o_err  out  1  access (i_ren or any i_wen) to an unmapped address

## Operation
- Decode:
  - RAM when i_addr < MEM_WORDS*4; word index = i_addr[log2(MEM_WORDS)+1:2].
  - MMIO when i_addr[31:6] == MMIO_BASE[31:6]; register select = i_addr[5:2].
  - Otherwise unmapped.
  - i_addr[1:0] is ignored everywhere.
- MMIO registers (offset: name, access, reset):
  - 0x00 CNT_LO, RW, 0
  - 0x04 CNT_HI, RW, 0
  - 0x08 CMP_LO, RW, 32'hFFFF_FFFF
  - 0x0C CMP_HI, RW, 32'hFFFF_FFFF
  - 0x10 CTRL, RW, 0: bit0 CNT_EN, bit1 IRQ_EN; other bits read 0
  - 0x14 STATUS, bit0 PEND is W1C, 0; other bits read 0
  - 0x18 GPIO, RW, 0
  - 0x1C–0x3C: read 0, writes ignored, o_err not asserted
- Byte lanes apply to every RW register: only enabled bytes change.
- Reads:
  - o_rd = selected word when i_ren = 1, else 0.
  - Unmapped reads return 0.
- Counter:
  - When CNT_EN = 1, {CNT_HI,CNT_LO} increments by 1 each cycle, 64-bit, wrapping to 0 after all-ones.
  - The carry from CNT_LO propagates into CNT_HI in the same cycle.
  - A software write to CNT_LO or CNT_HI takes precedence over the increment for that whole 64-bit update: written bytes take i_wd, unwritten bytes hold their pre-edge value with no increment.
- Compare:
  - PEND sets on any edge where the registered counter (unsigned 64-bit) >= {CMP_HI,CMP_LO}, independent of IRQ_EN.
  - PEND is sticky and cleared only by writing 1 to STATUS bit0.
  - If set and clear occur in the same cycle, set wins.
- o_irq = PEND & IRQ_EN.
- o_err = (i_ren | |i_wen) & unmapped, combinational.
- RAM contents are not reset and are X until written.

## Timing
- Read latency is 0 cycles (combinational from i_addr/i_ren).
- Write latency is 1 edge: the new value is visible on o_rd in the cycle after the write edge.
- A read and a write to the same address in the same cycle return the old value.
- A CNT read returns the pre-increment value of that cycle.
- o_irq is registered through PEND: it asserts the cycle after the counter reaches CMP, provided IRQ_EN = 1.
- Asynchronous reset:
  - Immediately: counter 0, CMP all-ones, CTRL 0, PEND 0, GPIO 0, o_irq 0, o_gpio 0.
  - o_rd and o_err follow the inputs.
  - A write in flight when reset asserts is dropped for registers; whether the RAM write commits is undefined.
- Reset deassertion must be synchronous to i_clk at the system level; the first edge after deassertion is a normal cycle.

## Test plan
- RAM byte lanes:
  - Write 32'hDEADBEEF to addr 0x10 with i_wen=4'hF, then 32'h0000_0055 with i_wen=4'b0001.
  - Read 0x10 (and 0x13, low bits ignored) -> o_rd = 32'hDEADBE55.
  - With i_ren=0 -> o_rd = 0.
- Counter carry:
  - Write CNT_LO=32'hFFFF_FFFE, CNT_HI=0, then CTRL=1.
  - Two cycles later CNT_LO=0 and CNT_HI=1.
  - Writing CNT_LO while enabled takes the written value, with no increment that cycle.
- Compare/IRQ:
  - CMP={0,5}, CTRL=3, counter starts at 0.
  - PEND and o_irq rise one cycle after CNT_LO reads 5.
  - Writing STATUS=1 while counter >= CMP leaves PEND=1 (set wins).
  - After setting CMP to all-ones and writing STATUS=1, PEND=0.
- GPIO:
  - Write GPIO=32'h1234_5678, then bytes i_wen=4'b1000 with 32'hAB00_0000 -> o_gpio = 32'hAB34_5678.
- Errors:
  - Read 0x4000_0000 -> o_rd=0, o_err=1.
  - Write there -> no state change, o_err=1.
  - Read MMIO_BASE+0x20 -> 0, o_err=0.
- Async reset:
  - Assert i_rstn low mid-cycle with counter running and PEND=1.
  - o_irq, o_gpio and the counter clear without a clock edge; after release, CMP reads 32'hFFFF_FFFF.
